// File: rtl/aleste_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aleste_wb_pkg
// Description : Shared Wishbone bus widths and the SRAM controller state type
// Revision    : 1.0 - initial release
// ============================================================================
package aleste_wb_pkg;

  localparam int WB_ADR_W = 24;
  localparam int WB_DAT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } sram_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_sram_ctrl
// Description : Wishbone classic slave driving an asynchronous 8-bit SRAM.
//               One address-setup cycle, WAIT_STATES strobe cycles, one
//               acknowledge/hold cycle. Only addresses inside the window
//               selected by BASE are answered.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_sram_ctrl
  import aleste_wb_pkg::*;
#(
  parameter int                  SRAM_AW     = 19,
  parameter logic [WB_ADR_W-1:0] BASE        = 24'h000000,
  parameter int                  WAIT_STATES = 1
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [WB_ADR_W-1:0] wb_adr_i,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  input  logic                wb_sel_i,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  output logic                wb_ack_o,
  output logic [SRAM_AW-1:0]  sram_a,
  output logic [WB_DAT_W-1:0] sram_d_o,
  input  logic [WB_DAT_W-1:0] sram_d_i,
  output logic                sram_d_oe,
  output logic                sram_nce,
  output logic                sram_noe,
  output logic                sram_nwe
);

  // Counter only needs to hold WAIT_STATES-1; keep at least one bit.
  localparam int            c_CNT_W    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam [c_CNT_W-1:0]  c_CNT_LOAD = c_CNT_W'(WAIT_STATES - 1);

  sram_state_t        r_state;
  logic               r_we;
  logic               r_sel;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_hit;
  logic               w_req;

  // Address window decode on the upper bits only
  assign w_hit = (wb_adr_i[WB_ADR_W-1:SRAM_AW] == BASE[WB_ADR_W-1:SRAM_AW]);
  assign w_req = wb_cyc_i & wb_stb_i & w_hit & ~wb_ack_o;

  // Transfer FSM; every SRAM pin is updated on the edge that enters a state,
  // so the pins reflect the state they belong to with no combinational path.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_sel     <= 1'b0;
      r_cnt     <= '0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      sram_a    <= '0;
      sram_d_o  <= '0;
      sram_d_oe <= 1'b0;
      sram_nce  <= 1'b1;
      sram_noe  <= 1'b1;
      sram_nwe  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state   <= SETUP;
            r_we      <= wb_we_i;
            r_sel     <= wb_sel_i;
            sram_a    <= wb_adr_i[SRAM_AW-1:0];
            sram_d_o  <= wb_dat_i;
            sram_nce  <= 1'b0;
            sram_noe  <= wb_we_i;
            sram_d_oe <= wb_we_i;
            sram_nwe  <= 1'b1;
          end
        end
        SETUP: begin
          if (!wb_cyc_i) begin
            r_state   <= IDLE;
            sram_nce  <= 1'b1;
            sram_noe  <= 1'b1;
            sram_nwe  <= 1'b1;
            sram_d_oe <= 1'b0;
          end else begin
            r_state  <= ACCESS;
            r_cnt    <= c_CNT_LOAD;
            // A deselected write still runs the cycle but never strobes nWE
            sram_nwe <= ~(r_we & r_sel);
          end
        end
        ACCESS: begin
          if (!wb_cyc_i) begin
            r_state   <= IDLE;
            sram_nce  <= 1'b1;
            sram_noe  <= 1'b1;
            sram_nwe  <= 1'b1;
            sram_d_oe <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state  <= DONE;
            wb_ack_o <= 1'b1;
            sram_noe <= 1'b1;
            sram_nwe <= 1'b1;
            if (!r_we) begin
              wb_dat_o <= sram_d_i;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          // Chip enable and data drive were held through this cycle
          r_state   <= IDLE;
          wb_ack_o  <= 1'b0;
          sram_nce  <= 1'b1;
          sram_noe  <= 1'b1;
          sram_nwe  <= 1'b1;
          sram_d_oe <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_sram_ctrl
// Description : Directed self-checking bench for wb_sram_ctrl with three
//               instances (WAIT_STATES=1, WAIT_STATES=3, offset window).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_sram_ctrl;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic        sel = 1'b0;
  logic [23:0] adr = '0;
  logic [7:0]  dat = '0;
  logic        cyc1 = 1'b0;
  logic        cyc3 = 1'b0;
  logic        cycm = 1'b0;

  logic [7:0]  dato1, do1, di1, dato3, do3, di3, datom, dom;
  logic [18:0] a1, a3, am;
  logic        ack1, doe1, nce1, noe1, nwe1;
  logic        ack3, doe3, nce3, noe3, nwe3;
  logic        ackm, doem, ncem, noem, nwem;

  logic [7:0]  mem1 [0:(1<<19)-1];
  logic [7:0]  mem3 [0:(1<<19)-1];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  wb_sram_ctrl #(.SRAM_AW(19), .BASE(24'h000000), .WAIT_STATES(1)) dut1 (
    .CLK(CLK), .nRESET(nRESET), .wb_cyc_i(cyc1), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(dato1), .wb_ack_o(ack1),
    .sram_a(a1), .sram_d_o(do1), .sram_d_i(di1), .sram_d_oe(doe1),
    .sram_nce(nce1), .sram_noe(noe1), .sram_nwe(nwe1));

  wb_sram_ctrl #(.SRAM_AW(19), .BASE(24'h000000), .WAIT_STATES(3)) dut3 (
    .CLK(CLK), .nRESET(nRESET), .wb_cyc_i(cyc3), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(dato3), .wb_ack_o(ack3),
    .sram_a(a3), .sram_d_o(do3), .sram_d_i(di3), .sram_d_oe(doe3),
    .sram_nce(nce3), .sram_noe(noe3), .sram_nwe(nwe3));

  wb_sram_ctrl #(.SRAM_AW(19), .BASE(24'h080000), .WAIT_STATES(1)) dutm (
    .CLK(CLK), .nRESET(nRESET), .wb_cyc_i(cycm), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(datom), .wb_ack_o(ackm),
    .sram_a(am), .sram_d_o(dom), .sram_d_i(8'h00), .sram_d_oe(doem),
    .sram_nce(ncem), .sram_noe(noem), .sram_nwe(nwem));

  // Asynchronous SRAM models: read while selected, write on rising nWE
  assign di1 = (!nce1 && !noe1) ? mem1[a1] : 8'hFF;
  assign di3 = (!nce3 && !noe3) ? mem3[a3] : 8'hFF;
  always @(posedge nwe1) if (nce1 === 1'b0) mem1[a1] <= do1;
  always @(posedge nwe3) if (nce3 === 1'b0) mem3[a3] <= do3;

  function automatic logic get_ack(input int which);
    case (which)
      1:       return ack1;
      3:       return ack3;
      default: return ackm;
    endcase
  endfunction

  function automatic logic get_nwe(input int which);
    case (which)
      1:       return nwe1;
      3:       return nwe3;
      default: return nwem;
    endcase
  endfunction

  function automatic logic [7:0] get_dat(input int which);
    case (which)
      1:       return dato1;
      3:       return dato3;
      default: return datom;
    endcase
  endfunction

  task automatic set_cyc(input int which, input logic v);
    case (which)
      1:       cyc1 = v;
      3:       cyc3 = v;
      default: cycm = v;
    endcase
  endtask

  // Bus master: holds the request until ack (bounded), reports edges to ack
  task automatic xfer(input int which, input logic w, input logic [23:0] a,
                      input logic [7:0] d, input logic s,
                      output int lat, output logic [7:0] rd, output int nwe_low);
    adr = a; we = w; dat = d; sel = s; stb = 1'b1;
    set_cyc(which, 1'b1);
    lat = 0; nwe_low = 0; rd = '0;
    while (lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      if (get_nwe(which) == 1'b0) nwe_low++;
      if (get_ack(which)) break;
    end
    rd = get_dat(which);
    stb = 1'b0;
    set_cyc(which, 1'b0);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (ack1 !== 1'b0 || dato1 !== 8'h00) begin
      errors++; $display("FAIL reset_wb: ack=%b dat=%h expected ack=0 dat=00", ack1, dato1);
    end
    checks++;
    if ({nce1, noe1, nwe1, doe1} !== 4'b1110) begin
      errors++; $display("FAIL reset_strobes: nce/noe/nwe/doe=%b expected 1110", {nce1, noe1, nwe1, doe1});
    end
    checks++;
    if (a1 !== 19'h0 || do1 !== 8'h00) begin
      errors++; $display("FAIL reset_addr_data: a=%h d_o=%h expected 0/00", a1, do1);
    end
    checks++;
    if (ack3 !== 1'b0 || nce3 !== 1'b1 || ackm !== 1'b0 || ncem !== 1'b1) begin
      errors++; $display("FAIL reset_others: ack3=%b nce3=%b ackm=%b ncem=%b expected 0101", ack3, nce3, ackm, ncem);
    end
    @(negedge CLK) nRESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_read_ws1();
    int doe_bad;
    doe_bad = 0;
    mem1[19'h12345] = 8'hA5;
    adr = 24'h012345; we = 1'b0; sel = 1'b1; stb = 1'b1; cyc1 = 1'b1;
    @(posedge CLK); #1;
    if (doe1 !== 1'b0) doe_bad++;
    checks++;
    if (noe1 !== 1'b0 || ack1 !== 1'b0 || nce1 !== 1'b0) begin
      errors++; $display("FAIL rd1_setup: noe=%b ack=%b nce=%b expected 0 0 0", noe1, ack1, nce1);
    end
    checks++;
    if (a1 !== 19'h12345) begin
      errors++; $display("FAIL rd1_addr: a=%h expected 12345", a1);
    end
    @(posedge CLK); #1;
    if (doe1 !== 1'b0) doe_bad++;
    checks++;
    if (noe1 !== 1'b0 || ack1 !== 1'b0) begin
      errors++; $display("FAIL rd1_access: noe=%b ack=%b expected 0 0", noe1, ack1);
    end
    @(posedge CLK); #1;
    if (doe1 !== 1'b0) doe_bad++;
    checks++;
    if (ack1 !== 1'b1) begin
      errors++; $display("FAIL rd1_ack: ack=%b expected 1 at N+3", ack1);
    end
    checks++;
    if (dato1 !== 8'hA5) begin
      errors++; $display("FAIL rd1_data: dat=%h expected a5", dato1);
    end
    checks++;
    if (noe1 !== 1'b1) begin
      errors++; $display("FAIL rd1_done_noe: noe=%b expected 1", noe1);
    end
    stb = 1'b0; cyc1 = 1'b0;
    @(posedge CLK); #1;
    if (doe1 !== 1'b0) doe_bad++;
    checks++;
    if (ack1 !== 1'b0 || nce1 !== 1'b1) begin
      errors++; $display("FAIL rd1_ack_width: ack=%b nce=%b expected 0 1", ack1, nce1);
    end
    checks++;
    if (doe_bad != 0) begin
      errors++; $display("FAIL rd1_doe: d_oe high in %0d cycles expected 0", doe_bad);
    end
  endtask

  task automatic test_write_ws3();
    int nlow, ack_at, acks, bad_d;
    int lat, nl;
    logic [7:0] rd;
    nlow = 0; ack_at = 0; acks = 0; bad_d = 0;
    adr = 24'h000010; we = 1'b1; dat = 8'h3C; sel = 1'b1; stb = 1'b1; cyc3 = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (nce3 !== 1'b0 || nwe3 !== 1'b1 || doe3 !== 1'b1) begin
      errors++; $display("FAIL wr3_setup: nce=%b nwe=%b doe=%b expected 0 1 1", nce3, nwe3, doe3);
    end
    for (int i = 1; i <= 10; i++) begin
      @(posedge CLK); #1;
      if (nwe3 == 1'b0) begin
        nlow++;
        if (do3 !== 8'h3C || doe3 !== 1'b1) bad_d++;
      end
      if (ack3) begin
        acks++;
        if (ack_at == 0) ack_at = i + 1;
        checks++;
        if (doe3 !== 1'b1 || nce3 !== 1'b0 || nwe3 !== 1'b1) begin
          errors++; $display("FAIL wr3_done_hold: doe=%b nce=%b nwe=%b expected 1 0 1", doe3, nce3, nwe3);
        end
        stb = 1'b0; cyc3 = 1'b0;
      end
    end
    checks++;
    if (nlow != 3) begin
      errors++; $display("FAIL wr3_nwe_width: nwe low %0d cycles expected 3", nlow);
    end
    checks++;
    if (bad_d != 0) begin
      errors++; $display("FAIL wr3_data: %0d strobe cycles with wrong d_o/doe expected 0", bad_d);
    end
    checks++;
    if (ack_at != 5 || acks != 1) begin
      errors++; $display("FAIL wr3_ack: ack at N+%0d count %0d expected N+5 count 1", ack_at, acks);
    end
    checks++;
    if (doe3 !== 1'b0 || nce3 !== 1'b1) begin
      errors++; $display("FAIL wr3_idle: doe=%b nce=%b expected 0 1", doe3, nce3);
    end
    xfer(3, 1'b0, 24'h000010, 8'h00, 1'b1, lat, rd, nl);
    checks++;
    if (lat != 5 || rd !== 8'h3C) begin
      errors++; $display("FAIL wr3_readback: lat=%0d dat=%h expected 5 3c", lat, rd);
    end
  endtask

  task automatic test_miss();
    int bad;
    int lat, nl;
    logic [7:0] rd;
    bad = 0;
    adr = 24'h000010; we = 1'b0; sel = 1'b1; stb = 1'b1; cycm = 1'b1;
    repeat (20) begin
      @(posedge CLK); #1;
      if (ackm !== 1'b0 || ncem !== 1'b1) bad++;
    end
    stb = 1'b0; cycm = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL miss_ignored: %0d cycles with ack or nce active expected 0", bad);
    end
    xfer(0, 1'b0, 24'h080010, 8'h00, 1'b1, lat, rd, nl);
    checks++;
    if (lat != 3) begin
      errors++; $display("FAIL hit_offset_ack: lat=%0d expected 3", lat);
    end
    checks++;
    if (am !== 19'h00010) begin
      errors++; $display("FAIL hit_offset_addr: a=%h expected 00010", am);
    end
  endtask

  task automatic test_sel0();
    int lat, nl;
    logic [7:0] rd;
    mem1[19'h00020] = 8'h11;
    xfer(1, 1'b1, 24'h000020, 8'h77, 1'b0, lat, rd, nl);
    @(posedge CLK); #1;
    checks++;
    if (lat != 3 || nl != 0) begin
      errors++; $display("FAIL sel0_write: lat=%0d nwe_low=%0d expected 3 0", lat, nl);
    end
    checks++;
    if (mem1[19'h00020] !== 8'h11) begin
      errors++; $display("FAIL sel0_mem: mem=%h expected 11", mem1[19'h00020]);
    end
    xfer(1, 1'b1, 24'h000020, 8'h77, 1'b1, lat, rd, nl);
    @(posedge CLK); #1;
    checks++;
    if (lat != 3 || nl != 1 || mem1[19'h00020] !== 8'h77) begin
      errors++; $display("FAIL sel1_write: lat=%0d nwe_low=%0d mem=%h expected 3 1 77", lat, nl, mem1[19'h00020]);
    end
    checks++;
    if (dato1 !== 8'hA5) begin
      errors++; $display("FAIL dat_hold: dat=%h expected a5", dato1);
    end
  endtask

  task automatic test_abort();
    int bad;
    int lat, nl;
    logic [7:0] rd;
    bad = 0;
    adr = 24'h000030; we = 1'b1; dat = 8'h99; sel = 1'b1; stb = 1'b1; cyc3 = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    checks++;
    if (nwe3 !== 1'b0) begin
      errors++; $display("FAIL abort_in_access: nwe=%b expected 0", nwe3);
    end
    cyc3 = 1'b0; stb = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if ({nce3, noe3, nwe3, doe3, ack3} !== 5'b11100) begin
      errors++; $display("FAIL abort_idle: nce/noe/nwe/doe/ack=%b expected 11100", {nce3, noe3, nwe3, doe3, ack3});
    end
    repeat (4) begin
      @(posedge CLK); #1;
      if (ack3 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL abort_no_ack: ack seen %0d cycles expected 0", bad);
    end
    xfer(3, 1'b0, 24'h000010, 8'h00, 1'b1, lat, rd, nl);
    checks++;
    if (lat != 5 || rd !== 8'h3C) begin
      errors++; $display("FAIL abort_then_read: lat=%0d dat=%h expected 5 3c", lat, rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nl;
    logic [7:0] rd;
    mem1[19'h00050] = 8'h5A;
    xfer(1, 1'b0, 24'h012345, 8'h00, 1'b1, lat, rd, nl);
    checks++;
    if (lat != 3 || rd !== 8'hA5) begin
      errors++; $display("FAIL b2b_first: lat=%0d dat=%h expected 3 a5", lat, rd);
    end
    xfer(1, 1'b0, 24'h000050, 8'h00, 1'b1, lat, rd, nl);
    checks++;
    if (lat != 4 || rd !== 8'h5A) begin
      errors++; $display("FAIL b2b_second: lat=%0d dat=%h expected 4 5a", lat, rd);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nl;
    logic [7:0] rd;
    adr = 24'h012345; we = 1'b0; sel = 1'b1; stb = 1'b1; cyc1 = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    #2 nRESET = 1'b0;
    #1;
    checks++;
    if ({nce1, noe1, nwe1, ack1} !== 4'b1110) begin
      errors++; $display("FAIL rst_mid_async: nce/noe/nwe/ack=%b expected 1110", {nce1, noe1, nwe1, ack1});
    end
    checks++;
    if (dato1 !== 8'h00 || a1 !== 19'h0) begin
      errors++; $display("FAIL rst_mid_regs: dat=%h a=%h expected 00 0", dato1, a1);
    end
    cyc1 = 1'b0; stb = 1'b0;
    @(negedge CLK) nRESET = 1'b1;
    @(posedge CLK); #1;
    xfer(1, 1'b0, 24'h012345, 8'h00, 1'b1, lat, rd, nl);
    checks++;
    if (lat != 3 || rd !== 8'hA5) begin
      errors++; $display("FAIL rst_mid_recover: lat=%0d dat=%h expected 3 a5", lat, rd);
    end
  endtask

  initial begin
    test_reset();
    test_read_ws1();
    test_write_ws3();
    test_miss();
    test_sel0();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
